arm_alu32_reg: RTL and testbench
================================

Name: arm_alu32_reg

Overview:
- 32-bit registered ALU datapath for the ARM-style core.
- Operand path: optional bitwise inversion of each operand (XOR with all-ones), then either a 32-bit ripple-carry adder or an 8-function logic unit.
- The selected result and NZCV flags are captured on a clock edge when the block is enabled.
- Feeds the register-file write-back and CPSR flag update logic.

Parameters:
- WIDTH, 32, datapath width. The flag rules below use bit WIDTH-1 as the sign bit. Only 32 is required to be verified.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- invert_a  input  1  use ~a instead of a (XOR with all-ones)
- invert_b  input  1  use ~b instead of b
- is_logic  input  1  1 = logic unit result, 0 = adder result
- logic_func_idx  input  3  logic function select
- cin  input  1  adder carry-in
- isactive  input  1  capture enable
- result  output  WIDTH  registered result
- N  output  1  registered negative flag
- Z  output  1  registered zero flag
- C  output  1  registered carry flag
- V  output  1  registered overflow flag
- valid  output  1  high for one cycle after each capture

Behaviour:
- Reset: while rst_n=0, asynchronously clear result, N, Z, C, V and valid to 0. Release takes effect on the next rising clk.
- Operand stage (combinational):
  - opa = a ^ {WIDTH{invert_a}}
  - opb = b ^ {WIDTH{invert_b}}
- Adder: full ripple-carry chain of WIDTH 1-bit full adders.
  - sum = opa + opb + cin, modulo 2^WIDTH
  - cout = carry out of bit WIDTH-1
- Logic unit on opa/opb, selected by logic_func_idx:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR
  - 6 pass opa, 7 pass opb
- Next result: is_logic ? logic_out : sum.
- Flags, computed from the next result:
  - N = result bit WIDTH-1
  - Z = 1 iff result is all zeros
  - Arithmetic mode (is_logic=0):
    - C = cout
    - V = (opa[31] == opb[31]) && (sum[31] != opa[31])
  - Logic mode (is_logic=1): C=0, V=0.
- Capture timing:
  - On a rising clk with isactive=1, register result and all four flags and set valid=1. Latency is exactly one cycle from input to output.
  - On a rising clk with isactive=0, result and flags hold their previous values and valid=0.
- Subtraction convention: A-B uses invert_b=1, cin=1. C=1 means no borrow.
- Inputs may change every cycle. There is no handshake or back-pressure.
- Mid-operation reset: asynchronous assertion of rst_n overrides any pending capture, and outputs read 0 immediately.
- Both inverts plus arithmetic mode is legal: sum = ~a + ~b + cin.
- X/undefined logic_func_idx values are not possible (all 8 codes are defined).

Test Plan:
- Reset: assert rst_n=0 mid-stream with isactive=1 -> result=0, NZCV=0000 and valid=0 immediately. The first capture after release is correct.
- Add: a=0x7FFFFFFF, b=0x00000001, cin=0, is_logic=0, isactive=1 -> next cycle result=0x80000000, N=1, Z=0, C=0, V=1, valid=1.
- Subtract equal: a=b=0x12345678, invert_b=1, cin=1 -> result=0, Z=1, C=1, V=0, N=0.
- Carry wrap: a=0xFFFFFFFF, b=0x00000001, cin=0 -> result=0, Z=1, C=1, V=0.
- Logic sweep: a=0xF0F0F0F0, b=0xFF00FF00, idx 0..7 -> 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0, 0x0FFF0FFF, 0x000F000F, 0xF00FF00F, 0xF0F0F0F0, 0xFF00FF00. Each has C=V=0; N per bit 31.
- Hold: capture one value, then drive new operands with isactive=0 for 3 cycles -> result and flags unchanged, valid=0. Re-assert isactive -> new value captured in one cycle.

Source files
------------

// File: rtl/arm_alu32_reg.sv
// Registered 32-bit ALU: operand inversion, ripple-carry adder or 8-function
// logic unit, with NZCV flags and a one-cycle valid strobe on each capture.
module arm_alu32_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             invert_a,
  input  logic             invert_b,
  input  logic             is_logic,
  input  logic [2:0]       logic_func_idx,
  input  logic             cin,
  input  logic             isactive,
  output logic [WIDTH-1:0] result,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             valid
);

  logic [WIDTH-1:0] opa, opb, sum, logic_out;
  logic             cout;
  logic [WIDTH-1:0] result_d, result_q;
  logic             n_d, z_d, c_d, v_d;
  logic             n_q, z_q, c_q, v_q, valid_q;

  assign opa = a ^ {WIDTH{invert_a}};
  assign opb = b ^ {WIDTH{invert_b}};

  // Explicit bit-serial chain so the adder stays a true ripple structure.
  always_comb begin : adder
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = opa[i] ^ opb[i] ^ carry;
      carry  = (opa[i] & opb[i]) | (carry & (opa[i] ^ opb[i]));
    end
    cout = carry;
  end

  always_comb begin
    logic_out = '0;
    unique case (logic_func_idx)
      3'd0: logic_out = opa & opb;
      3'd1: logic_out = opa | opb;
      3'd2: logic_out = opa ^ opb;
      3'd3: logic_out = ~(opa & opb);
      3'd4: logic_out = ~(opa | opb);
      3'd5: logic_out = ~(opa ^ opb);
      3'd6: logic_out = opa;
      3'd7: logic_out = opb;
      default: logic_out = '0;
    endcase
  end

  always_comb begin
    result_d = is_logic ? logic_out : sum;
    n_d      = result_d[WIDTH-1];
    z_d      = (result_d == '0);
    c_d      = 1'b0;
    v_d      = 1'b0;
    if (!is_logic) begin
      c_d = cout;
      v_d = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= isactive;
      if (isactive) begin
        result_q <= result_d;
        n_q      <= n_d;
        z_q      <= z_d;
        c_q      <= c_d;
        v_q      <= v_d;
      end
    end
  end

  assign result = result_q;
  assign N      = n_q;
  assign Z      = z_q;
  assign C      = c_q;
  assign V      = v_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_arm_alu32_reg.sv
// Directed and random checks of arm_alu32_reg against an arithmetic reference model.
module tb_arm_alu32_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        invert_a = 1'b0, invert_b = 1'b0, is_logic = 1'b0, cin = 1'b0, isactive = 1'b0;
  logic [2:0]  logic_func_idx = '0;
  logic [31:0] result;
  logic        N, Z, C, V, valid;

  int checks = 0;
  int passed = 0;

  logic [31:0] m_res;
  logic        m_n, m_z, m_c, m_v, m_valid;

  arm_alu32_reg #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .invert_a(invert_a), .invert_b(invert_b), .is_logic(is_logic),
    .logic_func_idx(logic_func_idx), .cin(cin), .isactive(isactive),
    .result(result), .N(N), .Z(Z), .C(C), .V(V), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".result"}, result, m_res);
    chk({tag, ".N"}, {31'b0, N}, {31'b0, m_n});
    chk({tag, ".Z"}, {31'b0, Z}, {31'b0, m_z});
    chk({tag, ".C"}, {31'b0, C}, {31'b0, m_c});
    chk({tag, ".V"}, {31'b0, V}, {31'b0, m_v});
    chk({tag, ".valid"}, {31'b0, valid}, {31'b0, m_valid});
  endtask

  task automatic model_reset();
    m_res = '0; m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_valid = 0;
  endtask

  // Reference: widened unsigned sum for carry, signed range test for overflow.
  task automatic model_capture();
    logic [31:0] oa, ob, r;
    longint      us, ss;
    oa = invert_a ? ~a : a;
    ob = invert_b ? ~b : b;
    us = longint'(oa) + longint'(ob) + longint'(cin);
    ss = longint'($signed(oa)) + longint'($signed(ob)) + longint'(cin);
    if (is_logic) begin
      case (logic_func_idx)
        3'd0: r = oa & ob;
        3'd1: r = oa | ob;
        3'd2: r = oa ^ ob;
        3'd3: r = ~(oa & ob);
        3'd4: r = ~(oa | ob);
        3'd5: r = ~(oa ^ ob);
        3'd6: r = oa;
        default: r = ob;
      endcase
      m_c = 0;
      m_v = 0;
    end else begin
      r   = us[31:0];
      m_c = (us >= 64'sh1_0000_0000);
      m_v = (ss > 64'sh7FFF_FFFF) || (ss < -64'sh8000_0000);
    end
    m_res = r;
    m_n   = r[31];
    m_z   = (r == 32'h0);
  endtask

  task automatic cycle(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                       input logic ia, input logic ib, input logic il, input logic [2:0] idx,
                       input logic ci, input logic act);
    @(negedge clk);
    a = ta; b = tb_; invert_a = ia; invert_b = ib; is_logic = il;
    logic_func_idx = idx; cin = ci; isactive = act;
    @(posedge clk);
    if (act) model_capture();
    m_valid = act;
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] sweep [8];
    sweep = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h0FFF0FFF,
              32'h000F000F, 32'hF00FF00F, 32'hF0F0F0F0, 32'hFF00FF00};
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    cycle("add_ovf", 32'h7FFFFFFF, 32'h00000001, 0, 0, 0, 3'd0, 0, 1);
    chk("add_ovf.const", result, 32'h80000000);
    chk("add_ovf.nzcv", {28'b0, N, Z, C, V}, 32'b1001);

    cycle("sub_eq", 32'h12345678, 32'h12345678, 0, 1, 0, 3'd0, 1, 1);
    chk("sub_eq.nzcv", {28'b0, N, Z, C, V}, 32'b0110);

    cycle("carry_wrap", 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 3'd0, 0, 1);
    chk("carry_wrap.nzcv", {28'b0, N, Z, C, V}, 32'b0110);

    for (int i = 0; i < 8; i++) begin
      cycle($sformatf("logic%0d", i), 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 1, 3'(i), 1, 1);
      chk($sformatf("logic%0d.const", i), result, sweep[i]);
    end

    cycle("both_inv", 32'h00000005, 32'h00000003, 1, 1, 0, 3'd0, 1, 1);

    cycle("hold_cap", 32'h00001234, 32'h00004321, 0, 0, 0, 3'd0, 0, 1);
    for (int i = 0; i < 3; i++)
      cycle($sformatf("hold%0d", i), $urandom, $urandom, 1'($urandom), 1'($urandom),
            1'($urandom), 3'($urandom), 1'($urandom), 0);
    chk("hold.const", result, 32'h00005555);
    cycle("hold_recap", 32'h80000000, 32'h80000000, 0, 0, 0, 3'd0, 0, 1);

    for (int i = 0; i < 200; i++)
      cycle("rand", $urandom, ($urandom_range(0, 3) == 0) ? 32'(~$urandom_range(0, 2)) : $urandom,
            1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
            ($urandom_range(0, 4) != 0));

    // Mid-stream reset with a capture pending.
    @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h1; invert_a = 0; invert_b = 0; is_logic = 0; cin = 0; isactive = 1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst", 32'h00000010, 32'h00000020, 0, 0, 0, 3'd0, 1, 1);
    chk("post_rst.const", result, 32'h00000031);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
